// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: byte-stream 3x3 Sobel edge filter with header parse and output FIFO.
// Optional SOBEL_HEADER_ECHO_EN: echo the 4 header bytes ahead of each frame's results.
module sobel_stream_filter #(
  parameter int MAX_WIDTH = 1024,
  parameter int OUT_FIFO_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_out
);
  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = $clog2(MAX_WIDTH);
  localparam logic [AW:0] FULL = (AW+1)'(OUT_FIFO_DEPTH);
  localparam logic [16:0] MAXW = 17'(MAX_WIDTH);
`ifdef SOBEL_HEADER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  typedef enum logic [1:0] {HDR, PIX, FLUSH, BYPASS} state_t;
  state_t state;
  logic live, acc, push, pop, full, interior, hdr_ok, last_col;
  logic [7:0] fifo [OUT_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [1:0] hidx;
  logic [15:0] w_reg, h_reg, h_new, row, col;
  logic [7:0] h_lo, push_data, mag;
  logic [31:0] remain, prod;
  logic [15:0] lb [MAX_WIDTH];
  logic [15:0] lb_rd;
  logic [23:0] w0, w1, nc;
  logic signed [11:0] gx, gy;
  logic [11:0] ax, ay;
  logic [12:0] sum;

  function automatic logic signed [11:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return $signed(12'(a) + 12'({b, 1'b0}) + 12'(c));
  endfunction

  // Window columns pack {row r-2, row r-1, row r}; nc is the column arriving with this pixel.
  always_comb begin
    count = wr_ptr - rd_ptr;
    full = count == FULL;
    valid_out = count != '0;
    data_out = valid_out ? fifo[rd_ptr[AW-1:0]] : 8'h00;
    ready_in = live && state != FLUSH && count <= FULL - (AW+1)'(2);
    acc = valid_in && ready_in;
    pop = valid_out && ready_out;
    lb_rd = lb[col[CW-1:0]];
    nc = {lb_rd, data_in};
    gx = wsum(nc[23:16], nc[15:8], nc[7:0]) - wsum(w0[23:16], w0[15:8], w0[7:0]);
    gy = wsum(w0[7:0], w1[7:0], nc[7:0]) - wsum(w0[23:16], w1[23:16], nc[23:16]);
    ax = gx[11] ? -gx : gx;
    ay = gy[11] ? -gy : gy;
    sum = {1'b0, ax} + {1'b0, ay};
    mag = |sum[12:8] ? 8'hFF : sum[7:0];
    h_new = {data_in, h_lo};
    prod = 32'(w_reg) * 32'(h_new);
    hdr_ok = w_reg >= 16'd3 && {1'b0, w_reg} <= MAXW && h_new >= 16'd3;
    last_col = col == w_reg - 16'd1;
    interior = state == PIX && row >= 16'd2 && col >= 16'd2;
    push = (state == HDR && acc && ECHO)
        || (state == PIX && acc && row != 16'd0 && !(row == 16'd1 && col == 16'd0))
        || (state == FLUSH && !full)
        || (state == BYPASS && acc);
    push_data = state == HDR ? data_in : interior ? mag : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= push_data;
    if (state == PIX && acc) lb[col[CW-1:0]] <= {lb_rd[7:0], data_in};
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= HDR;
      live <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      hidx <= '0;
      w_reg <= '0;
      h_reg <= '0;
      h_lo <= '0;
      row <= '0;
      col <= '0;
      remain <= '0;
      w0 <= '0;
      w1 <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        HDR: if (acc) begin
          hidx <= hidx + 2'd1;
          if (hidx == 2'd0) w_reg[7:0] <= data_in;
          if (hidx == 2'd1) w_reg[15:8] <= data_in;
          if (hidx == 2'd2) h_lo <= data_in;
          if (hidx == 2'd3) begin
            h_reg <= h_new;
            row <= '0;
            col <= '0;
            remain <= prod;
            state <= hdr_ok ? PIX : prod == '0 ? HDR : BYPASS;
          end
        end
        PIX: if (acc) begin
          w0 <= w1;
          w1 <= nc;
          col <= last_col ? 16'd0 : col + 16'd1;
          row <= last_col ? row + 16'd1 : row;
          if (last_col && row == h_reg - 16'd1) begin
            state <= FLUSH;
            remain <= {16'h0, w_reg} + 32'd1;
          end
        end
        FLUSH: if (!full) begin
          remain <= remain - 32'd1;
          if (remain == 32'd1) state <= HDR;
        end
        BYPASS: if (acc) begin
          remain <= remain - 32'd1;
          if (remain == 32'd1) state <= HDR;
        end
      endcase
    end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb_sobel_stream_filter: random and directed frames scored against a 2-D Sobel reference model.
module tb_sobel_stream_filter;
  logic clk = 1'b0, rst = 1'b0, valid_in = 1'b0, ready_out = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ready_in, valid_out;
  logic [7:0] data_out;
  int checks = 0, errors = 0, ro_pct = 100, vi_pct = 100;
  byte unsigned stream[$];
  byte unsigned exp_q[$];

  sobel_stream_filter dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int at(input byte unsigned px[$], input int w, input int r, input int c);
    return int'(px[r * w + c]);
  endfunction

  function automatic int ref_pix(input byte unsigned px[$], input int w, input int h, input int r, input int c);
    int gx, gy, m;
    if (r == 0 || c == 0 || r == h - 1 || c == w - 1) return 0;
    gx = at(px, w, r-1, c+1) + 2 * at(px, w, r, c+1) + at(px, w, r+1, c+1)
       - at(px, w, r-1, c-1) - 2 * at(px, w, r, c-1) - at(px, w, r+1, c-1);
    gy = at(px, w, r+1, c-1) + 2 * at(px, w, r+1, c) + at(px, w, r+1, c+1)
       - at(px, w, r-1, c-1) - 2 * at(px, w, r-1, c) - at(px, w, r-1, c+1);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return m > 255 ? 255 : m;
  endfunction

  task automatic put_hdr(input byte unsigned b);
    stream.push_back(b);
`ifdef SOBEL_HEADER_ECHO_EN
    exp_q.push_back(b);
`endif
  endtask

  // mode: 0 zeros, 1 single 255 at index 17, 2 left half 0 / right half 100, 3 random
  task automatic add_frame(input int w, input int h, input int mode);
    byte unsigned px[$];
    bit ok;
    put_hdr(8'(w));
    put_hdr(8'(w >> 8));
    put_hdr(8'(h));
    put_hdr(8'(h >> 8));
    for (int i = 0; i < w * h; i++) begin
      px.push_back(mode == 0 ? 8'd0 : mode == 1 ? (i == 17 ? 8'd255 : 8'd0) :
                   mode == 2 ? ((i % w) >= w / 2 ? 8'd100 : 8'd0) :
                   8'($urandom_range(255) >> $urandom_range(5)));
      stream.push_back(px[i]);
    end
    ok = w >= 3 && w <= 1024 && h >= 3;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back(ok ? 8'(ref_pix(px, w, h, r, c)) : 8'd0);
  endtask

  task automatic cycle();
    valid_in = stream.size() != 0 && $urandom_range(99) < vi_pct;
    data_in = stream.size() != 0 ? stream[0] : 8'h00;
    ready_out = $urandom_range(99) < ro_pct;
    @(negedge clk);
    if (valid_out && ready_out) begin
      chk("pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("data_out", data_out, exp_q.pop_front());
    end
    if (valid_in && ready_in) void'(stream.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((stream.size() != 0 || exp_q.size() != 0) && n < 30000) begin
      cycle();
      n++;
    end
    chk({tag, "_left"}, stream.size() + exp_q.size(), 0);
    ro_pct = 100;
    repeat (3) cycle();
    chk({tag, "_idle"}, valid_out, 0);
  endtask

  initial begin
    #12;
    chk("rst_ready_in", ready_in, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", ready_in, 1);
    add_frame(5, 7, 0);
    drain("zeros");
    add_frame(5, 7, 1);
    drain("dot");
    add_frame(4, 4, 2);
    drain("step");
    add_frame(2, 4, 0);
    drain("bypass");
    add_frame(0, 5, 0);
    add_frame(1025, 2, 3);
    add_frame(3, 3, 3);
    drain("invalid");
    for (int i = 0; i < 4; i++) begin
      ro_pct = $urandom_range(100, 30);
      vi_pct = $urandom_range(100, 50);
      add_frame($urandom_range(24, 3), $urandom_range(12, 3), 3);
      add_frame($urandom_range(24, 3), $urandom_range(12, 3), 3);
      drain("rand");
    end
    ro_pct = 100;
    vi_pct = 100;
    add_frame(40, 10, 3);
    ro_pct = 0;
    repeat (200) cycle();
    chk("bp_ready_in", ready_in, 0);
    chk("bp_valid_out", valid_out, 1);
`ifdef SOBEL_HEADER_ECHO_EN
    chk("bp_accepted", 404 - stream.size(), 104);
`else
    chk("bp_accepted", 404 - stream.size(), 108);
`endif
    ro_pct = 100;
    drain("bp");
    add_frame(10, 10, 3);
    ro_pct = 0;
    repeat (60) cycle();
    chk("mid_valid_out", valid_out, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid_out", valid_out, 0);
    chk("mid_rst_ready_in", ready_in, 0);
    chk("mid_rst_data_out", data_out, 0);
    stream.delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    ro_pct = 100;
    add_frame(4, 4, 3);
    drain("post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
- Byte-stream 3x3 Sobel edge filter placed between a UART receiver and a UART transmitter.
- Accepts a 4-byte frame header (width, height), then width*height 8-bit grayscale pixels in raster order.
- Emits one 8-bit gradient-magnitude byte per pixel, in raster order, through a small output FIFO with a valid/ready handshake.

Parameters:
- MAX_WIDTH, 1024, maximum supported image width; sets line-buffer depth.
- OUT_FIFO_DEPTH, 64, output FIFO entries (power of two).

Ports:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- data_in, in, 8, header or pixel byte.
- valid_in, in, 1, one-cycle strobe marking data_in valid.
- ready_in, out, 1, high when a byte can be accepted.
- data_out, out, 8, output byte (head of FIFO).
- valid_out, out, 1, FIFO non-empty.
- ready_out, in, 1, downstream consumes head byte this cycle (may be a single-cycle pulse).

Behaviour:
- Reset (rst=0, asynchronous) forces the following, from any state including mid-frame:
  - data_out=0, valid_out=0, ready_in=0.
  - FIFO emptied, counters cleared, state=HDR.
- After reset release: ready_in=1 whenever the FIFO has at least 2 free entries.
- Input transfer: valid_in && ready_in. A byte presented with ready_in=0 is dropped; counters do not advance.
- Output transfer: valid_out && ready_out pops the FIFO.
  - data_out always shows the FIFO head.
  - Push and pop in the same cycle is legal; occupancy is unchanged.
- States:
  - HDR: collects 4 bytes: W[7:0], W[15:8], H[7:0], H[15:8] (little-endian). After byte 4:
    - if 3<=W<=MAX_WIDTH and H>=3, go to PIX;
    - otherwise go to BYPASS.
  - PIX: each accepted pixel is written into two line buffers (rows r-1, r-2) and a 3x3 window shift register.
    - For every accepted pixel at raster index k>=W+1, push the result for raster index k-W-1 (lag of one row plus one pixel).
    - After the last pixel (k=W*H-1), go to FLUSH.
  - FLUSH: pushes the remaining W+1 results, all of which are zero (last row and last column), one per cycle while the FIFO is not full. Then go to HDR. ready_in=0 during FLUSH.
  - BYPASS: accepts W*H bytes and pushes 0x00 for each, then goes to HDR. If W*H=0, go straight to HDR.
- Result for pixel (r,c), using window p[i][j] with i = row offset 0..2 and j = column offset 0..2 around (r,c):
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
  - Both computed as 12-bit signed values.
  - mag = |Gx| + |Gy|, saturated to 255.
  - Border pixels (r=0, r=H-1, c=0, c=W-1) output 0x00.
- Exactly W*H result bytes per frame, in raster order. The next frame header may begin immediately after FLUSH.
- Pushes are never lost: PIX only accepts a pixel while the FIFO has room for that cycle's push.

Optional Feature:
- Macro SOBEL_HEADER_ECHO_EN.
  - Defined: the 4 header bytes are pushed to the FIFO unchanged as they are received, ahead of that frame's pixel results. Each frame then outputs W*H+4 bytes.
  - Undefined: no header echo; each frame outputs W*H bytes.

Test Plan:
- Header 05 00 07 00, then 35 zero pixels -> 35 output bytes, all 0x00; returns to HDR.
- Header 05 00 07 00, then 17 zeros, 255, 17 zeros -> output bytes at indices 11,12,13,16,18,21,22,23 = 0xFF; all others 0x00.
- 4x4 frame with left half 0 and right half 100 -> interior outputs 0xFF (400 saturated); borders 0x00.
- Header with W=2, H=4 -> 8 bytes accepted, 8 zeros output (BYPASS).
- Hold ready_out=0 while streaming a large frame -> FIFO fills, ready_in falls; releasing ready_out drains FIFO with no bytes lost or duplicated.
- Reset pulse mid-PIX -> valid_out=0 and FIFO empty immediately; next 4 bytes are parsed as a new header.
